pipe_stage_chain: RTL and testbench

- Parametrised elastic pipeline register chain for the MIPS core; successor to the fixed IF/ID and ID/EX latches.
- Carries a WIDTH-bit payload through STAGES register slots. Each slot has its own valid bit.
- Uses valid/ready backpressure instead of a global write-enable. Empty slots collapse ("bubble squeeze").
- Provides per-stage flush for branch/jump squash, plus occupancy and stall-cycle monitors for hazard and performance logic.

---
 rtl/pipe_stage_chain.sv | 107 ++++++++++
 tb/tb_pipe_stage_chain.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with per-slot flush,
// bubble squeeze, occupancy and saturating stall monitor.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_data/in_ready    : upstream handshake into slot 0
//   out_valid/out_data/out_ready : downstream handshake from last slot
//   flush[STAGES]                : squash slot i (slot 0 = youngest)
//   occupancy                    : registered count of valid slots
//   stall_cnt, stall_clr         : saturating stall-cycle counter
module pipe_stage_chain #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  input  logic [STAGES-1:0]           flush,
  output logic [$clog2(STAGES+1)-1:0] occupancy,
  output logic [CNT_W-1:0]            stall_cnt,
  input  logic                        stall_clr
);

  localparam int OW = $clog2(STAGES+1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ev;
  logic [STAGES-1:0] nv;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  d     [STAGES];
  logic [WIDTH-1:0]  src_d [STAGES];
  logic [OW-1:0]     nocc;

  assign ev = v & ~flush;

  // Ripple from the output back: a slot is ready when it is
  // effectively empty or everything downstream of it moves.
  always_comb begin : ready_chain
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      r      = ~ev[i] | r;
      rdy[i] = r;
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = ev[i-1];
      src_d[i] = d[i-1];
    end
  end

  // A held slot is always effectively valid, so v[i] is the
  // correct hold value even when flush is asserted elsewhere.
  always_comb begin
    nv   = '0;
    ld   = '0;
    nocc = '0;
    for (int i = 0; i < STAGES; i++) begin
      nv[i] = rdy[i] ? src_v[i] : v[i];
      ld[i] = rdy[i] & src_v[i];
      nocc  = nocc + OW'(nv[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++)
        d[i] <= '0;
    end else begin
      v         <= nv;
      occupancy <= nocc;
      for (int i = 0; i < STAGES; i++)
        if (ld[i]) d[i] <= src_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (out_valid && !out_ready &&
             stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign in_ready  = rdy[0];
  assign out_valid = ev[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=8, STAGES=3,
// CNT_W=4): reset, streaming, backpressure, squeeze, flush.
module tb_pipe_stage_chain;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] flush;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;
  logic       stall_clr;

  int errors = 0;
  int checks = 0;

  pipe_stage_chain #(
    .WIDTH(8), .STAGES(3), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .flush(flush), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; flush = '0; stall_clr = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data: got %h want 00", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rst_occ: got %0d want 0", occupancy);
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_stall: got %0d want 0", stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        occupancy !== 2'd0) begin
      errors++;
      $display("FAIL rel_state: got v=%b r=%b o=%0d want 0 1 0",
               out_valid, in_ready, occupancy);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      checks++;
      if (t >= 3 && t <= 8) begin
        if (out_valid !== 1'b1 || out_data !== 8'(t-2)) begin
          errors++;
          $display("FAIL stream_out t=%0d: got v=%b d=%h want 1 %h",
                   t, out_valid, out_data, 8'(t-2));
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stream_idle t=%0d: got v=%b want 0",
                 t, out_valid);
      end
      if (t < 6) begin
        in_valid = 1'b1;
        in_data  = 8'(t+1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_rdy t=%0d: got %b want 1",
                   t, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b0;
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + k);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept k=%0d: got %b want 1", k, in_ready);
      end
      tick();
    end
    checks++;
    if (occupancy !== 2'd3 || out_valid !== 1'b1 ||
        out_data !== 8'hA0) begin
      errors++;
      $display("FAIL bp_full: got o=%0d v=%b d=%h want 3 1 a0",
               occupancy, out_valid, out_data);
    end
    in_data = 8'hA3;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || stall_cnt !== 4'(k)) begin
        errors++;
        $display("FAIL bp_stall k=%0d: got r=%b s=%0d want 0 %0d",
                 k, in_ready, stall_cnt, k);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy: got %b want 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + k)) begin
        errors++;
        $display("FAIL bp_drain k=%0d: got v=%b d=%h want 1 %h",
                 k, out_valid, out_data, 8'(8'hA0 + k));
      end
      if (k > 0) in_valid = 1'b0;
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 ||
        stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL bp_empty: got v=%b o=%0d s=%0d want 0 0 3",
               out_valid, occupancy, stall_cnt);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    stall_clr = 1'b1;
    in_valid = 1'b1; in_data = 8'h10;
    tick();
    stall_clr = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'h20;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bub_rdy: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b1 ||
        out_valid !== 1'b1 || out_data !== 8'h10 ||
        stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL bub_state: got o=%0d r=%b v=%b d=%h s=%0d want 2 1 1 10 2",
               occupancy, in_ready, out_valid, out_data, stall_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h20) begin
      errors++;
      $display("FAIL bub_second: got v=%b d=%h want 1 20",
               out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL bub_empty: got v=%b o=%0d want 0 0",
               out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    stall_clr = 1'b1;
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    stall_clr = 1'b0;
    in_data = 8'h22;
    tick();
    in_data = 8'h11;
    tick();
    in_data = 8'h44;
    flush = 3'b011;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fl_comb: got r=%b v=%b want 1 1",
               in_ready, out_valid);
    end
    tick();
    flush = 3'b000;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || out_valid !== 1'b1 ||
        out_data !== 8'h33 || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL fl_state: got o=%0d v=%b d=%h s=%0d want 2 1 33 1",
               occupancy, out_valid, out_data, stall_cnt);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL fl_gap: got v=%b o=%0d want 0 1",
               out_valid, occupancy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h44) begin
      errors++;
      $display("FAIL fl_second: got v=%b d=%h want 1 44",
               out_valid, out_data);
    end
    out_ready = 1'b0;
    flush = 3'b100;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fl_mask: got v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
    tick();
    flush = 3'b000;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 ||
        stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL fl_empty: got o=%0d v=%b s=%0d want 0 0 1",
               occupancy, out_valid, stall_cnt);
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b0;
    stall_clr = 1'b1;
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    stall_clr = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    repeat (20) tick();
    checks++;
    if (stall_cnt !== 4'd15 || out_data !== 8'h55) begin
      errors++;
      $display("FAIL sat_cnt: got s=%0d d=%h want 15 55",
               stall_cnt, out_data);
    end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_clr: got %0d want 0", stall_cnt);
    end
    tick();
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL sat_resume: got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 8'hC1;
    tick();
    in_data = 8'hC2;
    tick();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd3 || stall_cnt !== 4'd3) begin
      errors++;
      $display("FAIL ar_full: got o=%0d s=%0d want 3 3",
               occupancy, stall_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 ||
        in_ready !== 1'b1 || occupancy !== 2'd0 ||
        stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL ar_clear: got v=%b d=%h r=%b o=%0d s=%0d want 0 00 1 0 0",
               out_valid, out_data, in_ready, occupancy, stall_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL ar_post k=%0d: got v=%b o=%0d want 0 0",
                 k, out_valid, occupancy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
